conv_operand_loader: RTL
========================

# conv_operand_loader

Operand-side sequencer for the CNN/Winograd ALU path. It accepts a 4x4 input tile plus a 3x3 kernel as a 25-byte stream and packs the bytes into the fixed 14-word operand sequence the accelerator captures. It issues those words one per handshake, then waits for the packed 32-bit result and unpacks it into four output bytes. It sits between the tile-fetch logic and the ALU operand/result port.

## Interface
- RES_TIMEOUT, 255: maximum cycles in WAIT_RES before abort (1..65535).
- MARK_BIT, 16: bit position forced to 1 in every operand word so that no word is ever zero (16..31).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input byte valid.
- in_ready  out  1  loader accepts a byte (high only in LOAD).
- in_data  in  8  tile/kernel byte.
- op_valid  out  1  operand word valid (high only in SEND).
- op_ready  in  1  ALU side accepts the word.
- op_word  out  32  operand word.
- op_last  out  1  high with word index 13.
- res_valid  in  1  result valid.
- res_ready  out  1  high only in WAIT_RES.
- res_data  in  32  packed result: four signed 8-bit outputs at [31:24],[23:16],[15:8],[7:0].
- out_valid  out  1  output byte valid (high only in DRAIN).
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  result byte.
- out_last  out  1  high with the 4th byte.
- busy  out  1  state != LOAD, or byte count != 0.
- tile_count  out  16  completed tiles; wraps from 0xFFFF to 0.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: LOAD, SEND, WAIT_RES, DRAIN. Reset state is LOAD.
- LOAD: on each handshake (in_valid && in_ready), in_data goes to byte buffer b[cnt] and cnt increments. When the handshake on byte 24 occurs, the FSM goes to SEND with cnt=0 and word idx=0.
- Packing (word j: [15:8]=hi, [7:0]=lo, [MARK_BIT]=1, all other bits 0):
  - j=0..8: hi=b[2j], lo=b[2j+1].
  - j=9: hi=b[18], lo=0.
  - j=10: hi=b[19], lo=b[20].
  - j=11: hi=b[21], lo=0.
  - j=12: hi=b[22], lo=b[23].
  - j=13: hi=b[24], lo=0.
- SEND: op_word is driven from a register for the current idx and stays stable while op_valid && !op_ready. On each handshake idx increments. The handshake on idx 13 moves the FSM to WAIT_RES and clears the timeout counter.
- WAIT_RES: res_ready=1.
  - On res_valid, res_data is latched and the FSM goes to DRAIN with byte idx 0.
  - Each cycle without res_valid increments the timer. When the timer reaches RES_TIMEOUT: set err, go to LOAD, clear cnt, do not increment tile_count.
- DRAIN: bytes are emitted in order [31:24], [23:16], [15:8], [7:0]; out_data advances only on a handshake. The 4th handshake goes to LOAD, clears cnt, and increments tile_count.
- Only one of in_ready/op_valid/res_ready/out_valid is ever high at a time. Bytes offered outside LOAD are not consumed.

## Timing
- Reset values: in_ready=1, op_valid=0, op_word=0, op_last=0, res_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, tile_count=0, err=0, cnt=0, idx=0, timer=0.
- Asserting rst mid-operation aborts immediately to LOAD. Partial buffers are discarded and no tile_count update occurs.
- One byte per cycle max in LOAD. op_valid rises the cycle after byte 24 is accepted.
- With all handshakes always ready, one tile takes 25 (LOAD) + 14 (SEND) + 1+ (WAIT_RES, result-dependent) + 4 (DRAIN) cycles.
- op_valid and out_valid, once high, stay high with stable data until accepted; they never drop without a handshake.
- A res_valid arriving in the same cycle the timer reaches RES_TIMEOUT wins: the result is captured and err is not set.
- The LOAD entered after DRAIN asserts in_ready in the next cycle, so there is no bubble beyond the state change.

## Test plan
- Stream bytes 0x01..0x19 with all ready signals high. Required:
  - op_word sequence 0x00010102, 0x00010304, … 0x00011112, 0x00011300, 0x00011415, 0x00011600, 0x00011718, 0x00011900.
  - op_last only on the 14th word.
- All-zero tile. Every op_word equals 0x00010000 (marker set, never zero), or the matching value for non-default MARK_BIT.
- Hold op_ready low for 5 cycles on word 3, and out_ready low on byte 2. Required: op_word and out_data stable throughout, no duplicate or skipped word/byte.
- res_data=0x80FF7F01. Required: out_data 0x80, 0xFF, 0x7F, 0x01; out_last on 0x01; tile_count increments by 1.
- Never assert res_valid with RES_TIMEOUT=8. Required: err=1 after 8 WAIT_RES cycles, back to LOAD, tile_count unchanged, the next tile processes normally.
- Pulse rst low during SEND idx 7. Required: all outputs at reset values asynchronously; the next full tile produces the correct 14 words from word 0.

Source files
------------

// File: rtl/conv_operand_loader.sv
// Operand-side sequencer: collects a 25-byte tile+kernel stream, issues 14 packed
// operand words to the ALU, then unpacks the 32-bit result into four output bytes.
module conv_operand_loader #(
    parameter int RES_TIMEOUT = 255,
    parameter int MARK_BIT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_word,
    output logic        op_last,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] tile_count,
    output logic        err
);

    typedef enum logic [1:0] {LOAD, SEND, WAIT_RES, DRAIN} state_t;

    localparam int          NBYTES      = 25;
    localparam int          NWORDS      = 14;
    localparam logic [31:0] MARK        = 32'(1) << MARK_BIT;
    localparam logic [15:0] TIMEOUT_VAL = 16'(RES_TIMEOUT);
    localparam logic [4:0]  LAST_BYTE   = 5'(NBYTES - 1);
    localparam logic [3:0]  LAST_WORD   = 4'(NWORDS - 1);

    state_t           state_reg, state_next;
    logic [4:0]       cnt_reg;
    logic [3:0]       idx_reg;
    logic [1:0]       byte_idx_reg;
    logic [15:0]      timer_reg;
    logic [31:0]      op_word_reg;
    logic [3:0][7:0]  res_reg;
    logic [15:0]      tile_count_reg;
    logic             err_reg;
    logic [7:0]       byte_buf [0:NBYTES-1];
    logic [31:0]      word_tab [0:NWORDS-1];
    logic             timer_expired;

    assign timer_expired = !res_valid && ((timer_reg + 16'd1) == TIMEOUT_VAL);

    // Fixed packing: 9 byte pairs, then the remaining 7 bytes alternate single / pair.
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_pack
            localparam int HI = (gi < 9)   ? 2*gi :
                                (gi == 9)  ? 18 :
                                (gi == 10) ? 19 :
                                (gi == 11) ? 21 :
                                (gi == 12) ? 22 : 24;
            localparam int LO = (gi < 9) ? 2*gi + 1 : (gi == 10) ? 20 : 23;
            localparam bit HAS_LO = (gi < 9) || (gi == 10) || (gi == 12);
            if (HAS_LO) begin : g_pair
                assign word_tab[gi] = MARK | {16'h0000, byte_buf[HI], byte_buf[LO]};
            end else begin : g_single
                assign word_tab[gi] = MARK | {16'h0000, byte_buf[HI], 8'h00};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            LOAD:     if (in_valid && cnt_reg == LAST_BYTE) state_next = SEND;
            SEND:     if (op_ready && idx_reg == LAST_WORD) state_next = WAIT_RES;
            WAIT_RES: begin
                if (res_valid) begin
                    state_next = DRAIN;
                end else if (timer_expired) begin
                    state_next = LOAD;
                end
            end
            DRAIN:    if (out_ready && byte_idx_reg == 2'd3) state_next = LOAD;
            default:  state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        out_valid = 1'b0;
        op_last   = 1'b0;
        out_last  = 1'b0;
        unique case (state_reg)
            LOAD:     in_ready = 1'b1;
            SEND: begin
                op_valid = 1'b1;
                op_last  = (idx_reg == LAST_WORD);
            end
            WAIT_RES: res_ready = 1'b1;
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (byte_idx_reg == 2'd3);
            end
            default:  in_ready = 1'b0;
        endcase
    end

    // Byte buffer is never read before being rewritten, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_reg == LOAD && in_valid) begin
            byte_buf[cnt_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            byte_idx_reg   <= '0;
            timer_reg      <= '0;
            op_word_reg    <= '0;
            res_reg        <= '0;
            tile_count_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            unique case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt_reg == LAST_BYTE) begin
                            cnt_reg     <= '0;
                            idx_reg     <= '0;
                            op_word_reg <= word_tab[0];
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                end
                SEND: begin
                    if (op_ready) begin
                        if (idx_reg == LAST_WORD) begin
                            timer_reg <= '0;
                        end else begin
                            idx_reg     <= idx_reg + 4'd1;
                            op_word_reg <= word_tab[idx_reg + 4'd1];
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_reg      <= res_data;
                        byte_idx_reg <= '0;
                    end else if (timer_expired) begin
                        err_reg <= 1'b1;
                        cnt_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            tile_count_reg <= tile_count_reg + 16'd1;
                            cnt_reg        <= '0;
                        end
                    end
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Result bytes go out most-significant first.
    assign out_data   = res_reg[2'd3 - byte_idx_reg];
    assign op_word    = op_word_reg;
    assign busy       = (state_reg != LOAD) || (cnt_reg != 5'd0);
    assign tile_count = tile_count_reg;
    assign err        = err_reg;

endmodule
